// File: rtl/pipelined_barrel_shifter.sv
// pipelined_barrel_shifter
// Fully pipelined barrel shifter with logical/arithmetic/rotate modes,
// valid/ready flow control and a lost-bits (sticky) flag.
// Stage k shifts by 2**k when shamt[k] is set, then registers the result.
// Optional feature macro: PIPELINED_BARREL_SHIFTER_STICKY_EN
//   defined   -> per-stage sticky accumulators, out_sticky is live
//   undefined -> no sticky state, out_sticky tied to 0
module pipelined_barrel_shifter #(
  parameter int WIDTH   = 24,
  parameter int SHIFT_W = 5,
  parameter int TAG_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int S = SHIFT_W;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  // Stage registers: element k is the output register of stage k.
  logic [S-1:0]       valid_q;
  logic [WIDTH-1:0]   data_q  [S];
  logic [1:0]         op_q    [S];
  logic [SHIFT_W-1:0] shamt_q [S];
  logic [TAG_W-1:0]   tag_q   [S];

  // Stage inputs (previous register, or the input port for stage 0).
  logic [S-1:0]       src_valid_s;
  logic [WIDTH-1:0]   src_data_s  [S];
  logic [1:0]         src_op_s    [S];
  logic [SHIFT_W-1:0] src_shamt_s [S];
  logic [TAG_W-1:0]   src_tag_s   [S];

  // Stage next-state data and load enables.
  logic [WIDTH-1:0]   data_d [S];
  logic [S-1:0]       load_s;

  // Route each stage's source: input port for stage 0, previous register otherwise.
  always_comb begin
    src_valid_s    = valid_q << 1;
    src_valid_s[0] = in_valid;
    src_data_s[0]  = in_data;
    src_op_s[0]    = in_op;
    src_shamt_s[0] = in_shamt;
    src_tag_s[0]   = in_tag;
    for (int k = 1; k < S; k++) begin
      src_data_s[k]  = data_q[k-1];
      src_op_s[k]    = op_q[k-1];
      src_shamt_s[k] = shamt_q[k-1];
      src_tag_s[k]   = tag_q[k-1];
    end
  end

  // Per-stage shift by 2**k when the stage's shamt bit is set.
  always_comb begin
    for (int k = 0; k < S; k++) begin
      data_d[k] = src_data_s[k];
      if (src_shamt_s[k][k]) begin
        case (src_op_s[k])
          OP_SLL: data_d[k] = src_data_s[k] << (32'd1 << k);
          OP_SRL: data_d[k] = src_data_s[k] >> (32'd1 << k);
          OP_SRA: data_d[k] = (src_data_s[k] >> (32'd1 << k))
                            | ({WIDTH{src_data_s[k][WIDTH-1]}} << (WIDTH - (32'd1 << k)));
          OP_ROR: data_d[k] = (src_data_s[k] >> (32'd1 << k))
                            | (src_data_s[k] << (WIDTH - (32'd1 << k)));
          default: data_d[k] = src_data_s[k];
        endcase
      end else begin
        data_d[k] = src_data_s[k];
      end
    end
  end

  // Stall chain: a stage loads when empty or when its contents move on.
  always_comb begin
    load_s        = '0;
    load_s[S-1]   = ~valid_q[S-1] | out_ready;
    for (int k = S - 2; k >= 0; k--) begin
      load_s[k] = ~valid_q[k] | load_s[k+1];
    end
  end

  assign in_ready = rst_n & load_s[0];

  // Pipeline registers: load on advance, hold when blocked, clear on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < S; k++) begin
        data_q[k]  <= '0;
        op_q[k]    <= '0;
        shamt_q[k] <= '0;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load_s[k]) begin
          valid_q[k] <= src_valid_s[k];
          data_q[k]  <= data_d[k];
          op_q[k]    <= src_op_s[k];
          shamt_q[k] <= src_shamt_s[k];
          tag_q[k]   <= src_tag_s[k];
        end
      end
    end
  end

  assign out_valid = valid_q[S-1];
  assign out_data  = data_q[S-1];
  assign out_tag   = tag_q[S-1];

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  logic [S-1:0] sticky_q;
  logic [S-1:0] src_sticky_s;
  logic [S-1:0] lost_s;

  // Bits each stage discards: LSB end for right shifts, MSB end for left.
  always_comb begin
    src_sticky_s = sticky_q << 1;
    lost_s       = '0;
    for (int k = 0; k < S; k++) begin
      if (src_shamt_s[k][k]) begin
        case (src_op_s[k])
          OP_SLL:  lost_s[k] = |(src_data_s[k] >> (WIDTH - (32'd1 << k)));
          OP_SRL:  lost_s[k] = |(src_data_s[k] << (WIDTH - (32'd1 << k)));
          OP_SRA:  lost_s[k] = |(src_data_s[k] << (WIDTH - (32'd1 << k)));
          OP_ROR:  lost_s[k] = 1'b0;
          default: lost_s[k] = 1'b0;
        endcase
      end else begin
        lost_s[k] = 1'b0;
      end
    end
  end

  // Sticky accumulators follow the same load/hold/reset rules as the data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      for (int k = 0; k < S; k++) begin
        if (load_s[k]) begin
          sticky_q[k] <= src_sticky_s[k] | lost_s[k];
        end
      end
    end
  end

  assign out_sticky = sticky_q[S-1];
`else
  assign out_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter: directed cases, back-pressure,
// mid-stream reset and a randomized stream against a behavioural model.
module tb_pipelined_barrel_shifter;

  localparam int W  = 24;
  localparam int SW = 5;
  localparam int TW = 4;

`ifdef PIPELINED_BARREL_SHIFTER_STICKY_EN
  localparam bit STICKY_ON = 1'b1;
`else
  localparam bit STICKY_ON = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0]  data;
    logic          sticky;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [SW-1:0] in_shamt;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_sticky;
  logic [TW-1:0] out_tag;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   sink_mode = 3;
  int   bp_start = 0;

  pipelined_barrel_shifter #(.WIDTH(W), .SHIFT_W(SW), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sticky(out_sticky), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: treat the operand as an integer, shift it in 64-bit space,
  // and read lost bits straight from what fell outside the window.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] d, input int s,
                                output logic [W-1:0] r, output logic st);
    logic [63:0] z, x, full, mask;
    int k;
    z    = 64'(d);
    x    = {{(64-W){d[W-1]}}, d};
    mask = (64'd1 << s) - 64'd1;
    case (op)
      2'b00: begin full = z << s; r = full[W-1:0]; st = |(full >> W); end
      2'b01: begin full = z >> s; r = full[W-1:0]; st = |(z & mask); end
      2'b10: begin full = x >> s; r = full[W-1:0]; st = |(x & mask); end
      default: begin
        k = s % W;
        full = (z >> k) | (z << (W - k));
        r = full[W-1:0];
        st = 1'b0;
      end
    endcase
  endfunction

  // Sink: drives out_ready per mode and checks in_ready under a full stall.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      case (sink_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 3) != 0);
        2: out_ready = !((cyc - bp_start) >= 6 && (cyc - bp_start) <= 9);
        default: out_ready = 1'b0;
      endcase
      if (sink_mode == 2 && (cyc - bp_start) == 9) begin
        #1;
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_out_valid_held", 64'(out_valid), 64'd1);
      end
    end
  end

  // Monitor: pops the scoreboard on every output transfer; checks stall stability.
  initial begin
    logic          hold;
    logic [W-1:0]  h_data;
    logic          h_sticky;
    logic [TW-1:0] h_tag;
    exp_t          e;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_data", 64'(out_data), 64'(h_data));
          check("stall_sticky", 64'(out_sticky), 64'(h_sticky));
          check("stall_tag", 64'(out_tag), 64'(h_tag));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("out_data", 64'(out_data), 64'(e.data));
            check("out_sticky", 64'(out_sticky), 64'(e.sticky));
            check("out_tag", 64'(out_tag), 64'(e.tag));
          end
        end
        hold     = out_valid && !out_ready;
        h_data   = out_data;
        h_sticky = out_sticky;
        h_tag    = out_tag;
      end
    end
  end

  // Present one op, wait (bounded) for acceptance, record its expectation.
  task automatic issue(input logic [1:0] op, input logic [W-1:0] d, input logic [SW-1:0] sh,
                       input logic [TW-1:0] tg, input bit use_exp,
                       input logic [W-1:0] ed, input logic es);
    exp_t e;
    logic [W-1:0] md;
    logic ms;
    int waited;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = sh; in_tag = tg;
    #1;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      model(op, d, int'(sh), md, ms);
      e.data   = use_exp ? ed : md;
      e.sticky = (use_exp ? es : ms) & STICKY_ON;
      e.tag    = tg;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // Called right after an accepted op: out_valid must show in the 5th cycle.
  task automatic lat_check(input string name);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check(name, 64'(lat), 64'd5);
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check(name, 64'(sb_q.size()), 64'd0);
  endtask

  // Directed table: op, data, shamt, expected data, expected sticky.
  logic [1:0]    d_op  [5] = '{2'b01, 2'b10, 2'b10, 2'b00, 2'b11};
  logic [W-1:0]  d_dat [5] = '{24'h800003, 24'h800000, 24'h800000, 24'hC00001, 24'h000001};
  logic [SW-1:0] d_sh  [5] = '{5'd2, 5'd4, 5'd31, 5'd1, 5'd25};
  logic [W-1:0]  d_exp [5] = '{24'h200000, 24'hF80000, 24'hFFFFFF, 24'h800002, 24'h800000};
  logic          d_st  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    logic [31:0] rnd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_sticky", 64'(out_sticky), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sink_mode = 0;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);

    // Directed cases, one at a time on an idle pipe.
    for (int i = 0; i < 5; i++) begin
      issue(d_op[i], d_dat[i], d_sh[i], 4'(i + 5), 1'b1, d_exp[i], d_st[i]);
      lat_check("latency");
      drain("directed_drain");
    end

    // Back-pressure: 8 ops streamed, out_ready low on relative cycles 6..9.
    @(posedge clk);
    #1;
    sink_mode = 2;
    bp_start  = cyc + 1;
    for (int i = 0; i < 8; i++) begin
      rnd = $urandom();
      issue(2'(i % 4), rnd[W-1:0], 5'(i * 3), 4'(i), 1'b0, '0, 1'b0);
    end
    drain("bp_drain");
    sink_mode = 0;

    // Reset with three ops in flight.
    for (int i = 0; i < 3; i++) begin
      rnd = $urandom();
      issue(2'b01, rnd[W-1:0], 5'd3, 4'(i + 9), 1'b0, '0, 1'b0);
    end
    sink_mode = 3;
    @(negedge clk);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sink_mode = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("midrst_no_valid", 64'(out_valid), 64'd0);
    end
    issue(2'b01, 24'h800003, 5'd2, 4'd5, 1'b1, 24'h200000, 1'b1);
    lat_check("midrst_latency");
    drain("midrst_drain");

    // Randomized stream with random back-pressure and input gaps.
    sink_mode = 1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      rnd = $urandom();
      issue(2'($urandom_range(0, 3)), rnd[W-1:0], 5'($urandom_range(0, 31)),
            4'(i), 1'b0, '0, 1'b0);
    end
    sink_mode = 0;
    drain("final_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
